// File: rtl/lane_arrival_queue_gen.sv
// Multi-lane random car arrival generator with per-lane saturating queues.
// Each lane owns an XNOR-feedback LFSR; an arrival happens when the lane's
// traffic level exceeds the current LFSR value. Departures drain the queue
// at one car every DEPART_DIV green cycles.
module lane_arrival_queue_gen #(
  parameter int LANES      = 2,
  parameter int W          = 5,
  parameter int QW         = 4,
  parameter int SEED       = 0,
  parameter int DEPART_DIV = 2
) (
  input  logic                  traffic_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [LANES*W-1:0]    traffic_level,
  input  logic [LANES-1:0]      green,
  output logic [LANES-1:0]      add_car,
  output logic [LANES-1:0]      depart_car,
  output logic [LANES*QW-1:0]   queue_count,
  output logic [LANES-1:0]      queue_full,
  output logic [LANES-1:0]      overflow
);

  // Divider counter needs at least one bit even when DEPART_DIV is 1.
  localparam int DW = (DEPART_DIV > 1) ? $clog2(DEPART_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DEPART_DIV - 1);
  localparam logic [QW-1:0] QMAX     = '1;

  // Feedback tap positions as a mask; unused bits are zero so they drop
  // out of the XNOR reduction.
  localparam logic [W-1:0] TAP_MASK =
      (W == 5) ? W'(8'h05) :
      (W == 6) ? W'(8'h03) :
      (W == 7) ? W'(8'h03) :
                 W'(8'h1D);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // Per-lane seed; the all-ones lock-up state is replaced by zero.
      localparam logic [W-1:0] SEED_X    = W'(SEED) ^ W'(gi);
      localparam logic [W-1:0] LANE_SEED = (&SEED_X) ? '0 : SEED_X;

      logic [W-1:0]  level;
      logic [W-1:0]  lfsr_reg,  lfsr_next;
      logic [QW-1:0] count_reg, count_next;
      logic [DW-1:0] div_reg,   div_next;
      logic          add_reg,   add_next;
      logic          dep_reg,   dep_next;
      logic          ovf_reg,   ovf_next;
      logic          fb;
      logic          arr;
      logic          dep;

      assign level = traffic_level[gi*W +: W];

      // Next-state logic for LFSR, divider and queue of this lane.
      always_comb begin
        fb         = ~^(lfsr_reg & TAP_MASK);
        lfsr_next  = {fb, lfsr_reg[W-1:1]};
        arr        = (level > lfsr_reg);
        dep        = green[gi] && (div_reg == DIV_LAST) && (count_reg != '0);
        div_next   = '0;
        if (green[gi]) begin
          div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        end
        count_next = count_reg;
        add_next   = 1'b0;
        dep_next   = 1'b0;
        ovf_next   = ovf_reg;
        if (arr && dep) begin
          // One in, one out: count unchanged even when full.
          add_next = 1'b1;
          dep_next = 1'b1;
        end else if (arr) begin
          if (count_reg != QMAX) begin
            count_next = count_reg + 1'b1;
            add_next   = 1'b1;
          end else begin
            ovf_next   = 1'b1;
          end
        end else if (dep) begin
          count_next = count_reg - 1'b1;
          dep_next   = 1'b1;
        end
      end

      // Lane state register; enable low freezes state and silences pulses.
      always_ff @(posedge traffic_clk) begin
        if (reset) begin
          lfsr_reg  <= LANE_SEED;
          count_reg <= '0;
          div_reg   <= '0;
          add_reg   <= 1'b0;
          dep_reg   <= 1'b0;
          ovf_reg   <= 1'b0;
        end else if (enable) begin
          lfsr_reg  <= lfsr_next;
          count_reg <= count_next;
          div_reg   <= div_next;
          add_reg   <= add_next;
          dep_reg   <= dep_next;
          ovf_reg   <= ovf_next;
        end else begin
          add_reg   <= 1'b0;
          dep_reg   <= 1'b0;
        end
      end

      assign add_car[gi]               = add_reg;
      assign depart_car[gi]            = dep_reg;
      assign queue_count[gi*QW +: QW]  = count_reg;
      assign queue_full[gi]            = (count_reg == QMAX);
      assign overflow[gi]              = ovf_reg;
    end
  endgenerate

endmodule
